// File: rtl/matrix_instr_writer_pkg.sv
// Shared constants, state encoding and helpers for the matrix instruction writer.
package matrix_instr_writer_pkg;

  localparam int unsigned WORD_W     = 224;
  localparam int unsigned ELEM_W     = 8;
  localparam int unsigned ELEM_COUNT = 25;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 2;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned SIZE_LSB   = 8;
  localparam int unsigned SIZE_MSB   = 15;
  localparam int unsigned MATRIX_LSB = 16;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned CNT_W      = $clog2(ELEM_COUNT);
  localparam int unsigned SIZE_MIN   = 1;
  localparam int unsigned SIZE_MAX   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIZE,
    ST_LOAD_A,
    ST_WRITE_A,
    ST_LOAD_B,
    ST_WRITE_B,
    ST_DONE
  } state_e;

  // Legal matrix dimension for the size byte.
  function automatic logic size_in_range(input logic [ELEM_W-1:0] size);
    return (size >= ELEM_W'(SIZE_MIN)) && (size <= ELEM_W'(SIZE_MAX));
  endfunction

endpackage

// File: rtl/matrix_word_packer.sv
// Element register file plus packing of opcode/size/elements into one memory word.
// word_c reflects the element being written this cycle, so the word is complete on the last byte.
module matrix_word_packer
  import matrix_instr_writer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CNT_W-1:0]    wr_idx,
  input  logic [ELEM_W-1:0]   wr_data,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ELEM_W-1:0]   size,
  output logic [WORD_W-1:0]   word_c
);

  logic [ELEM_W-1:0] elems_q [ELEM_COUNT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ELEM_COUNT; i++) elems_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < ELEM_COUNT; i++) begin
        if (wr_idx == CNT_W'(i)) elems_q[i] <= wr_data;
      end
    end
  end

  // Unused bits [7:3] and [223:216] stay zero.
  always_comb begin
    word_c = '0;
    word_c[OPCODE_MSB:OPCODE_LSB] = opcode;
    word_c[SIZE_MSB:SIZE_LSB]     = size;
    for (int unsigned i = 0; i < ELEM_COUNT; i++) begin
      if (wr_en && (wr_idx == CNT_W'(i))) word_c[MATRIX_LSB + ELEM_W*i +: ELEM_W] = wr_data;
      else                                word_c[MATRIX_LSB + ELEM_W*i +: ELEM_W] = elems_q[i];
    end
  end

endmodule

// File: rtl/matrix_instr_writer.sv
// Byte-stream loader that packs an opcode/size/A/B packet into two instruction memory words.
// Optional size check enabled by defining MATRIX_WRITER_SIZE_CHECK_EN.
module matrix_instr_writer
  import matrix_instr_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 3'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_byte,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [ELEM_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_d;
  logic                accept_c;
  logic                elem_we_c;
  logic                write_c;
  logic                ready_c;
  logic [WORD_W-1:0]   word_c;

  assign accept_c = in_valid && in_ready;

  matrix_word_packer u_packer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (elem_we_c),
    .wr_idx  (cnt_q),
    .wr_data (in_byte),
    .opcode  (opcode_q),
    .size    (size_q),
    .word_c  (word_c)
  );

  // Next-state, field capture and error tracking.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    err_d     = err;
    elem_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          opcode_d = in_byte[OPCODE_MSB:OPCODE_LSB];
          err_d    = 1'b0;
          state_d  = ST_SIZE;
        end
      end
      ST_SIZE: begin
        if (accept_c) begin
          size_d  = in_byte;
          cnt_d   = '0;
`ifdef MATRIX_WRITER_SIZE_CHECK_EN
          err_d   = !size_in_range(in_byte);
`endif
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (accept_c) begin
          elem_we_c = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ELEM_COUNT - 1)) begin
            state_d = (state_q == ST_LOAD_A) ? ST_WRITE_A : ST_WRITE_B;
          end
        end
      end
      ST_WRITE_A: begin
        cnt_d   = '0;
        state_d = ST_LOAD_B;
      end
      ST_WRITE_B: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`ifndef MATRIX_WRITER_SIZE_CHECK_EN
    err_d = 1'b0;
`endif
  end

  assign ready_c = (state_d == ST_IDLE) || (state_d == ST_SIZE) ||
                   (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
  // A flagged size suppresses both memory writes; err is already settled by then.
  assign write_c = ((state_d == ST_WRITE_A) || (state_d == ST_WRITE_B)) && !err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      err         <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= BASE_ADDR;
      mem_data    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      err      <= err_d;
      in_ready <= ready_c;
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
      mem_we   <= write_c;
      if (write_c) begin
        mem_address <= (state_d == ST_WRITE_A) ? BASE_ADDR : ADDR_W'(BASE_ADDR + ADDR_W'(1));
        mem_data    <= word_c;
      end
    end
  end

endmodule

// File: tb/tb_matrix_instr_writer.sv
// Randomized bench for matrix_instr_writer against a packet-level model; two instances (base 0 and 7).
module tb_matrix_instr_writer;

`ifdef MATRIX_WRITER_SIZE_CHECK_EN
  localparam bit SIZE_CHK = 1'b1;
`else
  localparam bit SIZE_CHK = 1'b0;
`endif

  localparam int EV_NONE = 0;
  localparam int EV_WA   = 1;
  localparam int EV_WB   = 2;
  localparam int EV_DONE = 3;

  localparam logic [223:0] LIT_A =
    224'h00_18_17_16_15_14_13_12_11_10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01_00_03_02;
  localparam logic [223:0] LIT_B =
    224'h00_98_97_96_95_94_93_92_91_90_8f_8e_8d_8c_8b_8a_89_88_87_86_85_84_83_82_81_80_03_02;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         rdy0, rdy7, we0, we7, busy0, busy7, done0, done7, err0, err7;
  logic [2:0]   addr0, addr7;
  logic [223:0] data0, data7;

  always #5 clk = ~clk;

  matrix_instr_writer #(.BASE_ADDR(3'd0)) dut0 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_byte(in_byte),
    .mem_address(addr0), .mem_data(data0), .mem_we(we0), .busy(busy0), .done(done0), .err(err0)
  );

  matrix_instr_writer #(.BASE_ADDR(3'd7)) dut7 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy7), .in_byte(in_byte),
    .mem_address(addr7), .mem_data(data7), .mem_we(we7), .busy(busy7), .done(done7), .err(err7)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  logic [7:0]   pm [52];
  int           evq [$];
  int           ev_cur = EV_NONE;
  int           n_acc = 0;
  bit           m_err = 1'b0, m_we = 1'b0, m_done = 1'b0, m_is_b = 1'b0;
  logic [223:0] m_data = '0;
  bit           model_ok = 1'b0;
  bit           acc_flag = 1'b0;
  int           cyc = 0;
  int           first_cyc = 0;

  function automatic logic [223:0] pack(input int first);
    logic [223:0] w;
    w = '0;
    w[2:0]  = pm[0][2:0];
    w[15:8] = pm[1];
    for (int k = 0; k < 25; k++) w[16 + 8*k +: 8] = pm[first + k];
    return w;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      evq.delete();
      ev_cur = EV_NONE; n_acc = 0; m_err = 1'b0; m_we = 1'b0; m_done = 1'b0;
      m_is_b = 1'b0; m_data = '0; acc_flag = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      acc_flag = in_valid && (ev_cur == EV_NONE);
      if (ev_cur == EV_DONE) n_acc = 0;
      if (acc_flag) begin
        if (n_acc == 0) first_cyc = cyc;
        pm[n_acc] = in_byte;
        n_acc++;
        if (n_acc == 1) m_err = 1'b0;
        if (n_acc == 2 && SIZE_CHK) m_err = (in_byte == 8'd0) || (in_byte > 8'd5);
        if (n_acc == 27) evq.push_back(EV_WA);
        if (n_acc == 52) begin evq.push_back(EV_WB); evq.push_back(EV_DONE); end
      end
      if (evq.size() > 0) ev_cur = evq.pop_front();
      else                ev_cur = EV_NONE;
      m_we = ((ev_cur == EV_WA) || (ev_cur == EV_WB)) && !m_err;
      if (m_we) begin
        m_is_b = (ev_cur == EV_WB);
        m_data = pack((ev_cur == EV_WA) ? 2 : 27);
      end
      m_done = (ev_cur == EV_DONE);
    end
    cyc++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready0", 224'(rdy0), 224'(ev_cur == EV_NONE));
      chk("in_ready7", 224'(rdy7), 224'(ev_cur == EV_NONE));
      chk("busy0", 224'(busy0), 224'(n_acc > 0));
      chk("busy7", 224'(busy7), 224'(n_acc > 0));
      chk("done0", 224'(done0), 224'(m_done));
      chk("done7", 224'(done7), 224'(m_done));
      chk("err0", 224'(err0), 224'(m_err));
      chk("err7", 224'(err7), 224'(m_err));
      chk("mem_we0", 224'(we0), 224'(m_we));
      chk("mem_we7", 224'(we7), 224'(m_we));
      chk("mem_address0", 224'(addr0), 224'(3'(m_is_b)));
      chk("mem_address7", 224'(addr7), 224'(3'(3'd7 + 3'(m_is_b))));
      chk("mem_data0", data0, m_data);
      chk("mem_data7", data7, m_data);
    end
  end

  // Memory image as written by each instance, plus the cycle of the last done pulse.
  logic [223:0] img0 [8];
  logic [223:0] img7 [8];
  int wr0 = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (we0) begin img0[addr0] = data0; wr0++; end
    if (we7) img7[addr7] = data7;
    if (done0) done_cyc = cyc;
  end

  // ---------------- stimulus ----------------
  logic [7:0] pkt [52];

  task automatic clear_img();
    for (int k = 0; k < 8; k++) begin img0[k] = '0; img7[k] = '0; end
  endtask

  task automatic fill_fixed(input logic [7:0] op, input logic [7:0] sz);
    pkt[0] = op; pkt[1] = sz;
    for (int k = 0; k < 25; k++) begin
      pkt[2 + k]  = 8'(k);
      pkt[27 + k] = 8'(8'h80 + k);
    end
  endtask

  task automatic fill_rand(input logic [7:0] sz);
    for (int k = 0; k < 52; k++) pkt[k] = 8'($urandom);
    pkt[1] = sz;
  endtask

  // gap: 0 = valid held high, 1 = toggle 1/0, 2 = random
  task automatic send(input int nbytes, input int gap);
    int i;
    int guard;
    bit tog;
    i = 0; guard = 0; tog = 1'b1;
    while (i < nbytes && guard < 2000) begin
      if (gap == 0)      in_valid = 1'b1;
      else if (gap == 1) in_valid = tog;
      else               in_valid = 1'($urandom_range(0, 1));
      tog = !tog;
      in_byte = in_valid ? pkt[i] : 8'($urandom);
      @(negedge clk);
      if (acc_flag) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < nbytes) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout actual=%0d required=%0d", i, nbytes);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((n_acc != 0 || ev_cur != EV_NONE || evq.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout actual=%0d required=0", n_acc);
    end
    @(negedge clk);
  endtask

  initial begin
    int wsnap;
    logic [7:0] sizes [5];
    bit bad;
    reset = 1'b1; in_valid = 1'b0; in_byte = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 224'(rdy0), 224'(1));
    chk("reset_mem_data", data0, 224'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed packet, valid held high
    clear_img();
    fill_fixed(8'h02, 8'h03);
    send(52, 0);
    wait_idle();
    chk("lit_word0", img0[0], LIT_A);
    chk("lit_word1", img0[1], LIT_B);
    chk("lit_base7_a", img7[7], LIT_A);
    chk("lit_base7_b_wrap", img7[0], LIT_B);
    chk("lit_done_cycle", 224'(done_cyc - first_cyc), 224'(54));

    // Same packet with valid toggling every cycle
    clear_img();
    send(52, 1);
    wait_idle();
    chk("lit_toggle_word0", img0[0], LIT_A);
    chk("lit_toggle_word1", img0[1], LIT_B);
    chk("lit_toggle_done_cycle", 224'(done_cyc - first_cyc), 224'(104));

    // Reset after byte 30: no B write; next packet must not carry stale elements
    fill_rand(8'd4);
    pkt[0] = 8'h05;
    send(31, 0);
    wsnap = wr0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("lit_no_write_after_reset", 224'(wr0 - wsnap), 224'(0));
    clear_img();
    fill_fixed(8'h02, 8'h03);
    send(52, 2);
    wait_idle();
    chk("lit_post_reset_word0", img0[0], LIT_A);
    chk("lit_post_reset_word1", img0[1], LIT_B);

    // Size byte boundaries
    sizes[0] = 8'd0; sizes[1] = 8'd6; sizes[2] = 8'hFF; sizes[3] = 8'd5; sizes[4] = 8'd1;
    for (int s = 0; s < 5; s++) begin
      clear_img();
      fill_rand(sizes[s]);
      wsnap = wr0;
      send(52, 0);
      wait_idle();
      bad = SIZE_CHK && ((sizes[s] == 8'd0) || (sizes[s] > 8'd5));
      chk("lit_size_err", 224'(err0), 224'(bad));
      chk("lit_size_writes", 224'(wr0 - wsnap), bad ? 224'(0) : 224'(2));
      if (!bad) chk("lit_size_field", 224'(img0[1][15:8]), 224'(sizes[s]));
    end

    // Random packets, random sizes and valid patterns
    for (int p = 0; p < 8; p++) begin
      fill_rand(8'($urandom_range(0, 7)));
      send(52, int'($urandom_range(0, 2)));
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
